// File: rtl/dcache_wbuf_axi.sv
// Write-back / uncached-store buffer on the D-cache AXI write side.
// Holds one victim line or one store word and replays it over AW/W/B.
module dcache_wbuf_axi #(
  parameter int LINE_WORDS = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wbuf_AXI_we,
  input  logic                      wbuf_AXI_reset,
  input  logic [32*LINE_WORDS-1:0]  line_in,
  input  logic [ADDR_W-1:0]         addr_in,
  input  logic [3:0]                strb_in,
  input  logic                      w_req,
  input  logic [7:0]                w_length,
  input  logic [2:0]                w_size,
  output logic                      w_rdy_AXI,
  output logic                      wrt_AXI_finish,
  output logic [ADDR_W-1:0]         awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [31:0]               wdata,
  output logic [3:0]                wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp,
  output logic                      bresp_err
);
  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int OFF_W = CNT_W + 2;

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       line_words [LINE_WORDS];
  logic [31:0]       line_reg   [LINE_WORDS];
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        strb_reg;
  logic [7:0]        len_reg;
  logic [2:0]        size_reg;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              finish_reg, err_reg;
  logic              idle, load, accept, b_done, single, full_line, last_beat;
  logic [CNT_W-1:0]  word_sel;

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_unpack
      assign line_words[gi] = line_in[32*gi +: 32];
    end
  endgenerate

  assign idle      = (state_reg == IDLE);
  // Loads are dropped while busy so the in-flight line is never overwritten.
  assign load      = idle && wbuf_AXI_we;
  assign accept    = idle && w_req;
  assign b_done    = (state_reg == B) && bvalid;
  assign single    = (len_reg == 8'd0);
  assign full_line = (len_reg == 8'(LINE_WORDS - 1));
  assign last_beat = (8'(cnt_reg) == len_reg);
  assign word_sel  = single ? addr_reg[OFF_W-1:2] : cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      strb_reg   <= '0;
      len_reg    <= '0;
      size_reg   <= '0;
      finish_reg <= 1'b0;
      err_reg    <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) line_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (load) begin
        addr_reg <= addr_in;
        strb_reg <= strb_in;
        for (int i = 0; i < LINE_WORDS; i++) line_reg[i] <= line_words[i];
      end
      if (accept) begin
        len_reg  <= w_length;
        size_reg <= w_size;
      end
      // A completing response outranks a simultaneous clear.
      if (b_done)
        finish_reg <= 1'b1;
      else if (wbuf_AXI_reset || accept)
        finish_reg <= 1'b0;
      if (b_done && (bresp != 2'b00))
        err_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    w_rdy_AXI  = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    bready     = 1'b0;
    case (state_reg)
      IDLE: begin
        w_rdy_AXI = 1'b1;
        if (w_req) state_next = AW;
      end
      AW: begin
        awvalid = 1'b1;
        if (awready) begin
          state_next = W;
          cnt_next   = '0;
        end
      end
      W: begin
        wvalid = 1'b1;
        wlast  = last_beat;
        if (wready) begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (last_beat) state_next = B;
        end
      end
      B: begin
        bready = 1'b1;
        if (bvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign awaddr         = full_line ? {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : addr_reg;
  assign awlen          = len_reg;
  assign awsize         = size_reg;
  assign awburst        = 2'b01;
  assign wdata          = line_reg[word_sel];
  assign wstrb          = single ? strb_reg : 4'hf;
  assign wrt_AXI_finish = finish_reg;
  assign bresp_err      = err_reg;
endmodule

// File: tb/tb_dcache_wbuf_axi.sv
// Bench for dcache_wbuf_axi: transaction-level model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_dcache_wbuf_axi;
  logic         clk = 1'b0, rst = 1'b1;
  logic         wbuf_AXI_we = 1'b0, wbuf_AXI_reset = 1'b0;
  logic [511:0] line_in = '0;
  logic [31:0]  addr_in = '0;
  logic [3:0]   strb_in = '0;
  logic         w_req = 1'b0;
  logic [7:0]   w_length = '0;
  logic [2:0]   w_size = '0;
  logic         w_rdy_AXI, wrt_AXI_finish;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid, awready = 1'b0;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast, wvalid, wready = 1'b0;
  logic         bvalid = 1'b0, bready;
  logic [1:0]   bresp = 2'b00;
  logic         bresp_err;

  int n_tests = 0, n_fail = 0;

  dcache_wbuf_axi #(.LINE_WORDS(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .wbuf_AXI_we(wbuf_AXI_we), .wbuf_AXI_reset(wbuf_AXI_reset),
    .line_in(line_in), .addr_in(addr_in), .strb_in(strb_in), .w_req(w_req),
    .w_length(w_length), .w_size(w_size), .w_rdy_AXI(w_rdy_AXI), .wrt_AXI_finish(wrt_AXI_finish),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bvalid(bvalid), .bready(bready), .bresp(bresp), .bresp_err(bresp_err)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: reactive readies with configurable delays.
  int   aw_delay = 0, b_delay = 0, aw_cnt = 0, b_cnt = 0;
  logic w_toggle = 1'b0, w_phase = 1'b0;
  logic [1:0] bresp_val = 2'b00;

  initial forever begin
    @(posedge clk); #1;
    aw_cnt  = awvalid ? aw_cnt + 1 : 0;
    awready = awvalid && (aw_cnt > aw_delay);
    w_phase = ~w_phase;
    wready  = wvalid && (!w_toggle || w_phase);
    b_cnt   = bready ? b_cnt + 1 : 0;
    bvalid  = bready && (b_cnt > b_delay);
    bresp   = bvalid ? bresp_val : 2'b00;
  end

  // Model: a captured buffer image and a queue of beats still owed to the slave.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] m_line [16];
  logic [31:0] m_addr = '0, m_awaddr = '0;
  logic [3:0]  m_strb = '0;
  logic [7:0]  m_len = '0;
  logic [2:0]  m_size = '0;
  logic        m_busy = 1'b0, m_aw_done = 1'b0, m_finish = 1'b0, m_err = 1'b0;
  logic        m_aw_hs, m_w_hs, m_b_hs, m_acc;

  function automatic logic exp_awvalid(); return m_busy && !m_aw_done; endfunction
  function automatic logic exp_wvalid();  return m_busy && m_aw_done && (exp_q.size() > 0); endfunction
  function automatic logic exp_bready();  return m_busy && m_aw_done && (exp_q.size() == 0); endfunction

  task automatic model_step();
    beat_t bt;
    if (rst) begin
      m_busy = 1'b0; m_aw_done = 1'b0; m_finish = 1'b0; m_err = 1'b0;
      m_addr = '0; m_strb = '0; m_len = '0; m_size = '0; m_awaddr = '0;
      for (int i = 0; i < 16; i++) m_line[i] = '0;
      exp_q.delete();
    end else begin
      m_aw_hs = exp_awvalid() && awready;
      m_w_hs  = exp_wvalid() && wready;
      m_b_hs  = exp_bready() && bvalid;
      m_acc   = !m_busy && w_req;
      if (m_b_hs) m_finish = 1'b1;
      else if (wbuf_AXI_reset || m_acc) m_finish = 1'b0;
      if (m_b_hs && bresp != 2'b00) m_err = 1'b1;
      if (!m_busy) begin
        if (wbuf_AXI_we) begin
          for (int i = 0; i < 16; i++) m_line[i] = line_in[32*i +: 32];
          m_addr = addr_in;
          m_strb = strb_in;
        end
        if (w_req) begin
          m_busy = 1'b1; m_aw_done = 1'b0; m_len = w_length; m_size = w_size;
          exp_q.delete();
          for (int i = 0; i <= int'(m_len); i++) begin
            bt.data = (m_len == 8'd0) ? m_line[m_addr[5:2]] : m_line[i % 16];
            bt.strb = (m_len == 8'd0) ? m_strb : 4'hf;
            bt.last = (i == int'(m_len));
            exp_q.push_back(bt);
          end
          m_awaddr = (m_len == 8'd15) ? {m_addr[31:6], 6'b0} : m_addr;
        end
      end else if (m_aw_hs) m_aw_done = 1'b1;
      else if (m_w_hs) exp_q.delete(0);
      else if (m_b_hs) m_busy = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Compare process: every cycle out of reset; also records observed W beats.
  logic [31:0] obs_data[$];
  logic        obs_last[$];

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("w_rdy_AXI", w_rdy_AXI, !m_busy);
      chk("awvalid", awvalid, exp_awvalid());
      chk("wvalid", wvalid, exp_wvalid());
      chk("bready", bready, exp_bready());
      chk("finish", wrt_AXI_finish, m_finish);
      chk("bresp_err", bresp_err, m_err);
      chk("awburst", awburst, 2'b01);
      if (exp_awvalid()) begin
        chk("awaddr", awaddr, m_awaddr);
        chk("awlen", awlen, m_len);
        chk("awsize", awsize, m_size);
      end
      if (exp_wvalid()) begin
        chk("wdata", wdata, exp_q[0].data);
        chk("wstrb", wstrb, exp_q[0].strb);
        chk("wlast", wlast, exp_q[0].last);
      end else chk("wlast_idle", wlast, 1'b0);
      if (wvalid && wready) begin
        obs_data.push_back(wdata);
        obs_last.push_back(wlast);
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic drive(input logic [31:0] base, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [7:0] len, input logic [2:0] size, input logic we, input logic req);
    for (int i = 0; i < 16; i++) line_in[32*i +: 32] = base + 32'(i);
    addr_in = addr; strb_in = strb; w_length = len; w_size = size;
    wbuf_AXI_we = we; w_req = req;
  endtask

  task automatic idle_in(); wbuf_AXI_we = 1'b0; w_req = 1'b0; wbuf_AXI_reset = 1'b0; endtask

  task automatic set_slave(input int awd, input logic tog, input int bd);
    aw_delay = awd; w_toggle = tog; b_delay = bd;
  endtask

  task automatic wait_obs(input int n, input string name);
    int k = 0;
    while (obs_data.size() < n && k < 200) begin step(); k++; end
    chk(name, obs_data.size() >= n, 1'b1);
  endtask

  task automatic wait_finish(input string name);
    int k = 0;
    while (wrt_AXI_finish !== 1'b1 && k < 300) begin step(); k++; end
    chk(name, wrt_AXI_finish, 1'b1);
  endtask

  task automatic check_line(input string name, input logic [31:0] base);
    chk({name, "_beats"}, obs_data.size(), 16);
    for (int i = 0; i < 16 && i < obs_data.size(); i++) begin
      chk({name, "_data"}, obs_data[i], base + 32'(i));
      chk({name, "_last"}, obs_last[i], i == 15);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_awvalid", awvalid, 0); chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);   chk("rst_wlast", wlast, 0);
    chk("rst_finish", wrt_AXI_finish, 0); chk("rst_err", bresp_err, 0);
    chk("rst_awaddr", awaddr, 0);   chk("rst_awlen", awlen, 0);
    chk("rst_awsize", awsize, 0);   chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", wstrb, 0);     chk("rst_awburst", awburst, 2'b01);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", w_rdy_AXI, 1);

    // Line burst, always-ready slave: load, then request next cycle
    step(); obs_data.delete(); obs_last.delete();
    drive(32'hA000_0000, 32'h1234_5678, 4'h0, 8'd15, 3'd2, 1'b1, 1'b0);
    step(); drive(32'hA000_0000, 32'h1234_5678, 4'h0, 8'd15, 3'd2, 1'b0, 1'b1);
    @(negedge clk); chk("t1_rdy_c0", w_rdy_AXI, 1);
    for (int c = 1; c <= 19; c++) begin
      step(); idle_in();
      @(negedge clk);
      chk("t1_awvalid_lat", awvalid, c == 1);
      chk("t1_wvalid_lat", wvalid, c >= 2 && c <= 17);
      chk("t1_bready_lat", bready, c == 18);
      chk("t1_finish_lat", wrt_AXI_finish, c == 19);
      if (c == 1) begin
        chk("t1_awaddr", awaddr, 32'h1234_5640);
        chk("t1_awlen", awlen, 8'd15);
        chk("t1_awsize", awsize, 3'd2);
      end
      if (c == 2) chk("t1_wstrb", wstrb, 4'hf);
    end
    step(); check_line("t1", 32'hA000_0000);

    // Uncached store, load and request in the same cycle
    obs_data.delete(); obs_last.delete();
    drive(32'h5555_0000, 32'h1FD0_0008, 4'b0011, 8'd0, 3'd1, 1'b1, 1'b1);
    line_in[95:64] = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      step(); idle_in();
      @(negedge clk);
      if (c == 1) begin
        chk("t2_awaddr", awaddr, 32'h1FD0_0008); chk("t2_awlen", awlen, 8'd0);
        chk("t2_awsize", awsize, 3'd1); chk("t2_finish_clr", wrt_AXI_finish, 0);
      end
      if (c == 2) begin
        chk("t2_wdata", wdata, 32'hDEAD_BEEF); chk("t2_wstrb", wstrb, 4'b0011);
        chk("t2_wlast", wlast, 1);
      end
      if (c == 3) chk("t2_bready", bready, 1);
      chk("t2_finish_lat", wrt_AXI_finish, c == 4);
    end

    // Backpressure, overwrite attempt at beat 5, flag reset mid-burst
    step(); obs_data.delete(); obs_last.delete();
    set_slave(3, 1'b1, 5);
    drive(32'hB000_0000, 32'h0000_1000, 4'h0, 8'd15, 3'd2, 1'b1, 1'b1);
    step(); idle_in();
    wait_obs(5, "t3_reach_beat5");
    drive(32'hC000_0000, 32'h0000_3000, 4'h5, 8'd0, 3'd0, 1'b1, 1'b1);
    wbuf_AXI_reset = 1'b1;
    step(); idle_in();
    wait_finish("t3_finish");
    check_line("t3", 32'hB000_0000);
    wbuf_AXI_reset = 1'b1;
    step(); idle_in();
    @(negedge clk); chk("t3_finish_cleared", wrt_AXI_finish, 0);

    // New load after returning to IDLE takes effect
    step(); obs_data.delete(); obs_last.delete();
    set_slave(0, 1'b0, 0);
    drive(32'hC000_0000, 32'h0000_2000, 4'h0, 8'd15, 3'd2, 1'b1, 1'b1);
    step(); idle_in();
    wait_finish("t3b_finish");
    check_line("t3b", 32'hC000_0000);

    // Flag reset coinciding with the B handshake: set wins
    obs_data.delete(); obs_last.delete();
    drive(32'h1111_0000, 32'h0000_0014, 4'hc, 8'd0, 3'd2, 1'b1, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step(); idle_in();
      wbuf_AXI_reset = (c == 3);
      @(negedge clk);
      if (c == 3) chk("t4_bready", bready, 1);
      if (c == 4) chk("t4_finish_set_wins", wrt_AXI_finish, 1);
    end
    step(); idle_in();
    chk("t4_beats", obs_data.size(), 1);
    if (obs_data.size() > 0) chk("t4_wdata", obs_data[0], 32'h1111_0005);

    // Async reset during beat 7 abandons the burst
    obs_data.delete(); obs_last.delete();
    chk("t5_err_before", bresp_err, 0);
    drive(32'h7700_0000, 32'h0000_0040, 4'h0, 8'd15, 3'd2, 1'b1, 1'b1);
    step(); idle_in();
    wait_obs(7, "t5_reach_beat7");
    @(negedge clk); #2; rst = 1'b1; #1;
    chk("t5_awvalid_drop", awvalid, 0); chk("t5_wvalid_drop", wvalid, 0);
    chk("t5_bready_drop", bready, 0);   chk("t5_wlast_drop", wlast, 0);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    chk("t5_rdy_after", w_rdy_AXI, 1); chk("t5_wdata_clr", wdata, 0);
    for (int c = 0; c < 3; c++) begin
      step(); @(negedge clk);
      chk("t5_no_finish", wrt_AXI_finish, 0);
      chk("t5_no_aw", awvalid, 0);
    end

    // Error response sets the sticky error flag
    step(); obs_data.delete(); obs_last.delete();
    bresp_val = 2'b10;
    drive(32'h3300_0000, 32'h0000_0008, 4'hf, 8'd0, 3'd2, 1'b1, 1'b1);
    step(); idle_in();
    wait_finish("t6_finish");
    @(negedge clk);
    chk("t6_bresp_err", bresp_err, 1);
    chk("t6_beats", obs_data.size(), 1);
    if (obs_data.size() > 0) chk("t6_wdata", obs_data[0], 32'h3300_0002);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_wbuf_axi.md
Name: dcache_wbuf_axi

Overview:
- Write-back / uncached-store buffer on the D-cache's AXI write side, directly downstream of the D-cache main FSM.
- Captures a victim cache line (16 words) or a single uncached store word when the FSM asserts wbuf_AXI_we.
- Accepts the FSM's w_req handshake and runs the AXI AW/W/B channels (INCR burst of 16 beats, or 1 beat).
- Reports w_rdy_AXI and a sticky wrt_AXI_finish back to the FSM.

Parameters:
- LINE_WORDS, 16, 32-bit words per cache line; beat counter width is log2(LINE_WORDS).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- wbuf_AXI_we  in  1  load pulse: capture line, addr and strb.
- wbuf_AXI_reset  in  1  clears wrt_AXI_finish.
- line_in  in  512  victim line; word i is bits [32i+31:32i].
- addr_in  in  32  write address (line victim tag/index, or uncached byte address).
- strb_in  in  4  byte strobe for an uncached store.
- w_req  in  1  FSM write request.
- w_length  in  8  AXI len: 15 = line burst, 0 = single beat.
- w_size  in  3  AXI size.
- w_rdy_AXI  out  1  buffer idle; w_req is accepted this cycle.
- wrt_AXI_finish  out  1  last B response received; sticky.
- awaddr  out  32  AXI write address.
- awlen  out  8  AXI burst length.
- awsize  out  3  AXI beat size.
- awburst  out  2  AXI burst type.
- awvalid  out  1  AW valid.
- awready  in  1  AW ready.
- wdata  out  32  W data.
- wstrb  out  4  W byte strobes.
- wlast  out  1  last W beat.
- wvalid  out  1  W valid.
- wready  in  1  W ready.
- bvalid  in  1  B valid.
- bready  out  1  B ready.
- bresp  in  2  B response.
- bresp_err  out  1  sticky: a B response with bresp != 0 was seen.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all registers 0.
  - Outputs: awvalid=wvalid=bready=wlast=0, wrt_AXI_finish=0, bresp_err=0, awaddr=0, awlen=0, awsize=0, wdata=0, wstrb=0.
  - awburst=2'b01 (INCR, constant); w_rdy_AXI=1 once reset is released.
  - Reset mid-transaction abandons the transfer; no completion is reported.
- States:
  - IDLE: w_rdy_AXI=1. wbuf_AXI_we loads line_in/addr_in/strb_in.
    - w_req=1: latch len=w_length and size=w_size; go to AW next cycle.
    - wbuf_AXI_we and w_req in the same cycle: the data loaded that cycle is what is sent.
  - AW: awvalid=1, awlen=len, awsize=size.
    - awaddr = {addr[31:6],6'b0} if len==15, else addr.
    - awready: go to W, beat counter cnt=0.
  - W: wvalid=1.
    - len==15: wdata=word[cnt], wstrb=4'hf.
    - len==0: wdata=word[addr[5:2]], wstrb=strb.
    - wlast = (cnt==len).
    - On wready: cnt+1; if wlast, go to B.
  - B: bready=1. On bvalid: set wrt_AXI_finish; set bresp_err if bresp!=0; go to IDLE.
- Busy rule: w_rdy_AXI=0 in AW, W, B.
  - wbuf_AXI_we is ignored while busy, so the in-flight line is never overwritten; the FSM may re-load on pipelined lookups.
  - w_req while busy is ignored.
- Finish flag:
  - Set on the B handshake.
  - Cleared on wbuf_AXI_reset, or when a new w_req is accepted in IDLE.
  - wbuf_AXI_reset while busy clears only the flag and does not abort the transfer.
  - Set and reset in the same cycle: set wins.
- No combinational paths from AXI ready/valid inputs to AXI outputs. All AXI outputs are registered state decodes or registered data.
- Latency with an always-ready slave: w_req accepted at cycle 0, awvalid at 1, W beats at 2..17, B at 18.
  - wrt_AXI_finish high from cycle 19 if bvalid arrives with bready.
  - Single beat: finish high from cycle 4.
- cnt wraps only by leaving W. An AXI len other than 0 or 15 is unsupported; the block sends len+1 beats, word[cnt] indexing.

Test Plan:
- Line burst: load line word i = 0xA000_0000+i, addr 0x1234_5678; w_req len=15 size=2 with all ready=1 -> awaddr=0x1234_5640, awlen=15; 16 beats 0xA0000000..0xA000000F with wstrb=f; wlast only on the 16th; wrt_AXI_finish=1 the cycle after bvalid.
- Uncached store: addr 0x1FD0_0008, strb 4'b0011, word[2]=0xDEAD_BEEF, len=0, size=1 -> awaddr=0x1FD0_0008, awlen=0, awsize=1; one beat wdata=0xDEADBEEF, wstrb=0011, wlast=1.
- Backpressure: awready delayed 3 cycles, wready toggling 1/0, bvalid delayed 5 cycles -> awvalid/wvalid held with stable data; beat order preserved; exactly 16 beats; w_rdy_AXI=0 throughout.
- Overwrite protection: wbuf_AXI_we pulsed with new line during beat 5 -> remaining beats still old data; after return to IDLE a new load takes effect.
- Finish/reset interplay: wbuf_AXI_reset asserted mid-burst -> burst completes and finish is set. A later reset pulse clears it. Reset and bvalid handshake in the same cycle -> finish=1.
- Async reset during W beat 7 -> all valids drop immediately; state IDLE; w_rdy_AXI=1 after release; bresp=2'b10 on a later write -> bresp_err=1.
